addr_decode_ws: RTL and testbench
=================================

Name: addr_decode_ws

Overview:
- Registered, parametrised successor to the combinational CPLD address decoder.
- Decodes the upper address bits of the 6502 bus into one-hot chip selects using a per-select base/mask table.
- Stretches slow-device cycles through a per-select wait-state counter driving the CPU RDY line.
- Sits between the CPU bus and the RAM/ROM/PIA/expansion selects.

Parameters:
ADDR_W, 4, number of upper address bits decoded (A15 downward)
NUM_CS, 6, number of chip-select outputs
WAIT_W, 3, width of each wait-state count (0..2**WAIT_W-1 cycles)
CS_BASE, {4'h8,4'hC,4'hE,4'hF,4'hD,4'h0}, packed NUM_CS*ADDR_W; entry i at [i*ADDR_W +: ADDR_W]
CS_MASK, {4'hC,4'hF,4'hF,4'hF,4'hF,4'h8}, packed NUM_CS*ADDR_W; 1 = bit compared
CS_WAIT, {3'd0,3'd0,3'd0,3'd2,3'd1,3'd0}, packed NUM_CS*WAIT_W; RDY-low cycles per select

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
enable  in  1  bus cycle valid (qualified address strobe)
addr  in  ADDR_W  upper address bits
rw  in  1  1 = read, 0 = write
cs  out  NUM_CS  registered one-hot chip selects, active high
rdy  out  1  to CPU RDY; 0 = stretch cycle
miss  out  1  one-cycle pulse when enable is accepted and no select hits
wp_fault  out  1  one-cycle pulse on a blocked write (only with ADDR_DECODE_WP_EN; otherwise tied 0)

Behaviour:
- Reset (reset_n=0 at a clk edge): cs=0, rdy=1, miss=0, wp_fault=0, counter=0, state=IDLE. Reset overrides everything, including mid-WAIT.
- Hit rule: hit[i] = ((addr & CS_MASK[i]) == (CS_BASE[i] & CS_MASK[i])).
- Priority: lowest index wins; cs is never more than one-hot. A mask of 0 matches all addresses.
- FSM states: IDLE, WAIT, HOLD.
- IDLE, enable=1, hit at index k:
  - next edge: cs <= 1<<k; cnt <= CS_WAIT[k].
  - if CS_WAIT[k]>0: rdy <= 0, go to WAIT; else go to HOLD with rdy staying 1.
- IDLE, enable=1, no hit: miss=1 for one cycle; cs stays 0; stay IDLE until enable=0. A new bus cycle is accepted only after enable has returned to 0 in IDLE, using an internal armed flag.
- WAIT: cnt decrements each cycle. At the edge where cnt==1: rdy <= 1, go to HOLD. rdy is low for exactly CS_WAIT[k] cycles.
- WAIT, enable=0 (abort): next edge cs <= 0, rdy <= 1, go to IDLE.
- HOLD: cs held. enable=0 → next edge cs <= 0, go to IDLE.
- Latency: cs valid 1 cycle after enable is sampled high; cs drops 1 cycle after enable is sampled low.
- addr and rw changes outside IDLE are ignored; the select is latched at acceptance.
- miss and wp_fault are single-cycle pulses, never sticky.

Optional Feature:
- Macro: ADDR_DECODE_WP_EN.
- Defined:
  - Adds parameter CS_WP (NUM_CS bits, default 6'b000100, i.e. ROM select 2 write-protected).
  - Accepted cycle with rw=0 hitting a select k where CS_WP[k]=1: cs stays 0, rdy stays 1, wp_fault=1 for one cycle, FSM waits in IDLE for enable=0.
  - Reads to that select are unaffected.
- Undefined: no CS_WP parameter; wp_fault tied 0; writes decode like reads.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with enable=1, addr=4'h0 → cs=0, rdy=1, miss=0 throughout; first accepted cycle after release gives cs=6'b000001.
- Full sweep: addr 0..15, enable=1 for 4 cycles then 0 for 2 cycles each; defaults → addr 0-7 cs=000001, 8-B 100000, C 010000, D 000010, E 001000, F 000100; never two bits set.
- Wait states: addr=F, rw=1, enable held → rdy low exactly 2 cycles starting the cycle cs asserts, then 1. Same test with addr=D → rdy low 1 cycle. Same test with addr=0 → rdy never low.
- Abort: addr=F, drop enable on the first rdy-low cycle → next cycle cs=0, rdy=1, state IDLE; a following addr=0 cycle decodes normally.
- Miss: instantiate with CS_MASK all 4'hF, addr=4'h1 → miss pulses exactly 1 cycle, cs=0, rdy=1; holding enable does not re-pulse.
- WP (ADDR_DECODE_WP_EN): addr=F, rw=0 → wp_fault 1 cycle, cs=0. Same with rw=1 → cs=000100 with 2 wait cycles. Without the macro, the rw=0 access gives cs=000100 and wp_fault=0.

Source files
------------

// File: rtl/addr_decode_ws.sv
// Registered 6502 address decoder: base/mask chip-select table with per-select RDY wait states.
// Optional write protection of selected chip selects is enabled by defining ADDR_DECODE_WP_EN.
module addr_decode_ws #(
    parameter int unsigned                    ADDR_W  = 4,
    parameter int unsigned                    NUM_CS  = 6,
    parameter int unsigned                    WAIT_W  = 3,
    parameter logic [NUM_CS*ADDR_W-1:0]       CS_BASE = {4'h8, 4'hC, 4'hE, 4'hF, 4'hD, 4'h0},
    parameter logic [NUM_CS*ADDR_W-1:0]       CS_MASK = {4'hC, 4'hF, 4'hF, 4'hF, 4'hF, 4'h8},
    parameter logic [NUM_CS*WAIT_W-1:0]       CS_WAIT = {3'd0, 3'd0, 3'd0, 3'd2, 3'd1, 3'd0}
`ifdef ADDR_DECODE_WP_EN
    ,
    parameter logic [NUM_CS-1:0]              CS_WP   = 6'b000100
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_enable,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rw,
    output logic [NUM_CS-1:0] o_cs,
    output logic              o_rdy,
    output logic              o_miss,
    output logic              o_wp_fault
);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    state_e              r_state, w_state_d;
    logic [NUM_CS-1:0]   r_cs, w_cs_d;
    logic [WAIT_W-1:0]   r_cnt, w_cnt_d;
    logic                r_rdy, w_rdy_d;
    logic                r_miss, w_miss_d;
    logic                r_armed, w_armed_d;
    logic                w_wp_d;

    logic [NUM_CS-1:0]   w_sel;
    logic [WAIT_W-1:0]   w_wait;
    logic                w_any;
    logic                w_wp_hit;
    logic                w_blocked;

    // Scan from the top so the lowest matching index is the one that survives.
    always_comb begin
        w_sel    = '0;
        w_wait   = '0;
        w_any    = 1'b0;
        w_wp_hit = 1'b0;
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            if ((i_addr & CS_MASK[i*ADDR_W +: ADDR_W]) ==
                (CS_BASE[i*ADDR_W +: ADDR_W] & CS_MASK[i*ADDR_W +: ADDR_W])) begin
                w_sel    = '0;
                w_sel[i] = 1'b1;
                w_wait   = CS_WAIT[i*WAIT_W +: WAIT_W];
                w_any    = 1'b1;
`ifdef ADDR_DECODE_WP_EN
                w_wp_hit = CS_WP[i];
`endif
            end
        end
    end

    assign w_blocked = w_wp_hit & ~i_rw;

    always_comb begin
        w_state_d = r_state;
        w_cs_d    = r_cs;
        w_cnt_d   = r_cnt;
        w_rdy_d   = r_rdy;
        w_miss_d  = 1'b0;
        w_wp_d    = 1'b0;
        // A new bus cycle may only start after enable has been seen low.
        w_armed_d = r_armed | ~i_enable;
        unique case (r_state)
            StIdle: begin
                if (i_enable && r_armed) begin
                    w_armed_d = 1'b0;
                    if (!w_any) begin
                        w_miss_d = 1'b1;
                    end else if (w_blocked) begin
                        w_wp_d = 1'b1;
                    end else begin
                        w_cs_d  = w_sel;
                        w_cnt_d = w_wait;
                        if (w_wait != '0) begin
                            w_rdy_d   = 1'b0;
                            w_state_d = StWait;
                        end else begin
                            w_state_d = StHold;
                        end
                    end
                end
            end
            StWait: begin
                if (!i_enable) begin
                    w_cs_d    = '0;
                    w_rdy_d   = 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end else if (r_cnt == WAIT_W'(1)) begin
                    w_rdy_d   = 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = StHold;
                end else begin
                    w_cnt_d = r_cnt - WAIT_W'(1);
                end
            end
            StHold: begin
                if (!i_enable) begin
                    w_cs_d    = '0;
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_cs_d    = '0;
                w_rdy_d   = 1'b1;
                w_cnt_d   = '0;
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
            r_cs    <= '0;
            r_cnt   <= '0;
            r_rdy   <= 1'b1;
            r_miss  <= 1'b0;
            r_armed <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_cs    <= w_cs_d;
            r_cnt   <= w_cnt_d;
            r_rdy   <= w_rdy_d;
            r_miss  <= w_miss_d;
            r_armed <= w_armed_d;
        end
    end

`ifdef ADDR_DECODE_WP_EN
    logic r_wp_fault;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wp_fault <= 1'b0;
        end else begin
            r_wp_fault <= w_wp_d;
        end
    end

    assign o_wp_fault = r_wp_fault;
`else
    assign o_wp_fault = 1'b0 & w_wp_d;
`endif

    assign o_cs   = r_cs;
    assign o_rdy  = r_rdy;
    assign o_miss = r_miss;

endmodule

// File: tb/tb_addr_decode_ws.sv
// Directed self-checking bench for addr_decode_ws: default table plus an all-mask-F instance
// used to provoke decode misses.
module tb_addr_decode_ws;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [3:0] addr;
    logic       rw;
    logic [5:0] cs, cs_m;
    logic       rdy, rdy_m;
    logic       miss, miss_m;
    logic       wp, wp_m;

    int n_checks = 0;
    int n_pass   = 0;

    addr_decode_ws dut (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_enable   (enable),
        .i_addr     (addr),
        .i_rw       (rw),
        .o_cs       (cs),
        .o_rdy      (rdy),
        .o_miss     (miss),
        .o_wp_fault (wp)
    );

    addr_decode_ws #(
        .CS_MASK ({6{4'hF}})
    ) dut_m (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_enable   (enable),
        .i_addr     (addr),
        .i_rw       (rw),
        .o_cs       (cs_m),
        .o_rdy      (rdy_m),
        .o_miss     (miss_m),
        .o_wp_fault (wp_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] exp_cs(input logic [3:0] a);
        if (a < 4'h8)       return 6'b000001;
        else if (a < 4'hC)  return 6'b100000;
        else if (a == 4'hC) return 6'b010000;
        else if (a == 4'hD) return 6'b000010;
        else if (a == 4'hE) return 6'b001000;
        else                return 6'b000100;
    endfunction

    task automatic idle_cycles(input int n);
        enable = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        addr    = 4'h0;
        rw      = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (cs !== 6'b0) $display("FAIL reset_cs cyc=%0d got=%b exp=000000", c, cs);
            else n_pass++;
            n_checks++;
            if (rdy !== 1'b1) $display("FAIL reset_rdy cyc=%0d got=%b exp=1", c, rdy);
            else n_pass++;
            n_checks++;
            if (miss !== 1'b0) $display("FAIL reset_miss cyc=%0d got=%b exp=0", c, miss);
            else n_pass++;
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (cs !== 6'b000001) $display("FAIL reset_first_cs got=%b exp=000001", cs);
        else n_pass++;
        idle_cycles(2);
    endtask

    task automatic test_sweep();
        logic [5:0] e;
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            rw   = 1'b1;
            enable = 1'b1;
            e = exp_cs(4'(a));
            for (int c = 0; c < 4; c++) begin
                tick();
                n_checks++;
                if (cs !== e || !$onehot(cs))
                    $display("FAIL sweep_cs addr=%h cyc=%0d got=%b exp=%b", a, c, cs, e);
                else n_pass++;
            end
            idle_cycles(2);
            n_checks++;
            if (cs !== 6'b0) $display("FAIL sweep_drop addr=%h got=%b exp=000000", a, cs);
            else n_pass++;
        end
    endtask

    task automatic wait_case(input logic [3:0] a, input int w);
        logic exp_rdy;
        addr   = a;
        rw     = 1'b1;
        enable = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp_rdy = (c <= w) ? 1'b0 : 1'b1;
            n_checks++;
            if (rdy !== exp_rdy)
                $display("FAIL wait_rdy addr=%h cyc=%0d got=%b exp=%b", a, c, rdy, exp_rdy);
            else n_pass++;
        end
        n_checks++;
        if (cs !== exp_cs(a)) $display("FAIL wait_cs addr=%h got=%b exp=%b", a, cs, exp_cs(a));
        else n_pass++;
        idle_cycles(2);
    endtask

    task automatic test_wait_states();
        wait_case(4'hF, 2);
        wait_case(4'hD, 1);
        wait_case(4'h0, 0);
    endtask

    task automatic test_abort();
        addr   = 4'hF;
        rw     = 1'b1;
        enable = 1'b1;
        tick();
        n_checks++;
        if (cs !== 6'b000100 || rdy !== 1'b0)
            $display("FAIL abort_start cs=%b rdy=%b exp cs=000100 rdy=0", cs, rdy);
        else n_pass++;
        enable = 1'b0;
        tick();
        n_checks++;
        if (cs !== 6'b0 || rdy !== 1'b1)
            $display("FAIL abort_drop cs=%b rdy=%b exp cs=000000 rdy=1", cs, rdy);
        else n_pass++;
        addr   = 4'h0;
        enable = 1'b1;
        tick();
        n_checks++;
        if (cs !== 6'b000001 || rdy !== 1'b1)
            $display("FAIL abort_next cs=%b rdy=%b exp cs=000001 rdy=1", cs, rdy);
        else n_pass++;
        idle_cycles(2);
    endtask

    task automatic test_latch();
        addr   = 4'hE;
        rw     = 1'b1;
        enable = 1'b1;
        tick();
        addr = 4'h0;
        rw   = 1'b0;
        tick();
        tick();
        n_checks++;
        if (cs !== 6'b001000) $display("FAIL latch_cs got=%b exp=001000", cs);
        else n_pass++;
        idle_cycles(2);
        rw = 1'b1;
    endtask

    task automatic test_miss();
        logic exp_m;
        addr   = 4'h1;
        rw     = 1'b1;
        enable = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            exp_m = (c == 1) ? 1'b1 : 1'b0;
            n_checks++;
            if (miss_m !== exp_m || cs_m !== 6'b0 || rdy_m !== 1'b1)
                $display("FAIL miss cyc=%0d miss=%b cs=%b rdy=%b exp miss=%b cs=000000 rdy=1",
                         c, miss_m, cs_m, rdy_m, exp_m);
            else n_pass++;
        end
        n_checks++;
        if (miss !== 1'b0 || cs !== 6'b000001)
            $display("FAIL miss_default miss=%b cs=%b exp miss=0 cs=000001", miss, cs);
        else n_pass++;
        idle_cycles(2);
    endtask

    task automatic test_wp();
        addr   = 4'hF;
        rw     = 1'b0;
        enable = 1'b1;
        tick();
`ifdef ADDR_DECODE_WP_EN
        n_checks++;
        if (wp !== 1'b1 || cs !== 6'b0 || rdy !== 1'b1)
            $display("FAIL wp_block wp=%b cs=%b rdy=%b exp wp=1 cs=000000 rdy=1", wp, cs, rdy);
        else n_pass++;
        tick();
        n_checks++;
        if (wp !== 1'b0 || cs !== 6'b0)
            $display("FAIL wp_pulse wp=%b cs=%b exp wp=0 cs=000000", wp, cs);
        else n_pass++;
`else
        n_checks++;
        if (wp !== 1'b0 || cs !== 6'b000100)
            $display("FAIL wp_off wp=%b cs=%b exp wp=0 cs=000100", wp, cs);
        else n_pass++;
        tick();
        n_checks++;
        if (wp !== 1'b0) $display("FAIL wp_off_hold wp=%b exp=0", wp);
        else n_pass++;
`endif
        idle_cycles(2);
        wait_case(4'hF, 2);
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_wait_states();
        test_abort();
        test_latch();
        test_miss();
        test_wp();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
